// File: rtl/edu_hamming_core.sv
// rtl/edu_hamming_core.sv - two-stage Hamming(7,4) flit corrector; EDU_ERR_CNT_EN adds err_count
// Stage1 holds the raw flit, stage2 the corrected flit and its error flag.
module edu_hamming_core #(
  parameter int WIDTH  = 11,
  parameter int ADDR_W = 4
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_flag
`ifdef EDU_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int CW_W = WIDTH - ADDR_W;

  logic             r_run;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_err;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_s2_load;
  logic [CW_W-1:0]  w_cw;
  logic [2:0]       w_syn;
  logic [CW_W-1:0]  w_fix;

  // r_run keeps in_ready low until the first edge after reset release
  assign in_ready   = r_run && (!r_s1_valid || !r_s2_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign err_flag   = r_s2_err;
  assign w_out_fire = r_s2_valid && out_ready;
  assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);

  assign w_cw     = r_s1_data[WIDTH-1:ADDR_W];
  assign w_syn[0] = w_cw[0] ^ w_cw[2] ^ w_cw[4] ^ w_cw[6];
  assign w_syn[1] = w_cw[1] ^ w_cw[2] ^ w_cw[5] ^ w_cw[6];
  assign w_syn[2] = w_cw[3] ^ w_cw[4] ^ w_cw[5] ^ w_cw[6];

  // Position p lives in codeword bit p-1; syndrome 0 matches no position
  always_comb begin
    w_fix = w_cw;
    for (int p = 0; p < CW_W; p++) begin
      w_fix[p] = w_cw[p] ^ (w_syn == 3'(p + 1));
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= in_data;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_data  <= {w_fix, r_s1_data[ADDR_W-1:0]};
      r_s2_err   <= (w_syn != 3'd0);
    end else if (w_out_fire) begin
      r_s2_valid <= 1'b0;
    end
  end

`ifdef EDU_ERR_CNT_EN
  logic [7:0] r_err_count;

  assign err_count = r_err_count;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_err_count <= 8'h00;
    end else if (w_out_fire && r_s2_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_edu_hamming_core.sv
// tb/tb_edu_hamming_core.sv - randomized scoreboard bench for edu_hamming_core
module tb_edu_hamming_core;

  logic        CLK;
  logic        _RESET;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic        err_flag;
`ifdef EDU_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  edu_hamming_core #(.WIDTH(11), .ADDR_W(4)) dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_flag  (err_flag)
`ifdef EDU_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc    = 0;
  int          n_out    = 0;
  int          exp_cnt  = 0;
  logic [11:0] exp_q[$];
  logic        held_v   = 1'b0;
  logic [11:0] held     = '0;

  logic [10:0] dir_in [4] = '{11'h000, 11'h7F5, 11'h103, 11'h7E5};
  logic [11:0] dir_exp[4] = '{12'h000, 12'h7F5, 12'h803, 12'hFF5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Syndrome as the XOR of the positions of all set bits; flip that position
  function automatic logic [11:0] ref_model(input logic [10:0] f);
    int         s  = 0;
    logic [6:0] cw = f[10:4];
    for (int p = 1; p <= 7; p++) begin
      if (cw[p-1]) s = s ^ p;
    end
    if (s != 0) cw[s-1] = ~cw[s-1];
    return {(s != 0), cw, f[3:0]};
  endfunction

  task automatic step(input logic v, input logic [10:0] d, input logic rdy);
    logic [11:0] e;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(negedge CLK);
    if (held_v) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {err_flag, out_data}, held);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e[10:0]);
        check("sb_flag", err_flag, e[11]);
        if (e[11] && exp_cnt < 255) exp_cnt++;
      end
    end
    if (in_valid && in_ready) begin
      n_acc++;
      exp_q.push_back(ref_model(d));
    end
    held_v = out_valid && !out_ready;
    held   = {err_flag, out_data};
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    _RESET = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    exp_q.delete();
    held_v  = 1'b0;
    exp_cnt = 0;
    @(posedge CLK);
    #3;
    _RESET = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(posedge CLK);
    #1;
    check("rel_in_ready_high", in_ready, 1);
  endtask

  initial begin
    int a0;
    int o0;
    _RESET    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 11'h7FF;
    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_data", out_data, 0);
    check("reset_err_flag", err_flag, 0);
`ifdef EDU_ERR_CNT_EN
    check("reset_err_count", err_count, 0);
`endif
    #2;
    _RESET = 1'b1;
    #1;
    check("release_in_ready_low", in_ready, 0);
    @(posedge CLK);
    #1;
    check("release_in_ready_high", in_ready, 1);
    check("release_no_accept", dut.r_s1_valid, 0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, dir_in[i], 1'b1);
      check("lat_early", out_valid, 0);
      step(1'b0, 11'h0, 1'b1);
      check("lat_valid", out_valid, 1);
      check("dir_data", out_data, dir_exp[i][10:0]);
      check("dir_flag", err_flag, dir_exp[i][11]);
      step(1'b0, 11'h0, 1'b1);
    end

    o0 = n_out;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) step(i < 8, 11'($urandom), 1'b1);
    check("stream_acc", n_acc - a0, 8);
    check("stream_out", n_out - o0, 8);

    a0 = n_acc;
    for (int i = 0; i < 5; i++) step(1'b1, 11'($urandom), 1'b0);
    check("bp_accepted", n_acc - a0, 2);
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 11'h0, 1'b1);
    check("bp_drained", exp_q.size(), 0);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(3, 0) != 0), 11'($urandom), ($urandom_range(3, 0) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 11'h0, 1'b1);
    check("rand_drained", exp_q.size(), 0);
`ifdef EDU_ERR_CNT_EN
    check("rand_err_count", err_count, 32'(exp_cnt));
`endif

    step(1'b1, 11'h103, 1'b0);
    step(1'b1, 11'h7E5, 1'b0);
    do_reset();
    o0 = n_out;
    for (int i = 0; i < 4; i++) step(1'b0, 11'h0, 1'b1);
    check("midrst_no_output", n_out - o0, 0);

`ifdef EDU_ERR_CNT_EN
    for (int i = 0; i < 300; i++) step(1'b1, {7'h10, 4'($urandom)}, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 11'h0, 1'b1);
    check("cnt_saturated", err_count, 8'hFF);
    do_reset();
    check("cnt_cleared", err_count, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
